reg_file_2w2r: RTL and testbench
================================

Name: reg_file_2w2r

Overview:
- Parametrised successor to the 1-bit, 2-entry, single-write-port register file.
- DEPTH entries of DATA_W bits, two write ports with fixed priority and two synchronous read ports with 1-cycle latency.
- Per-entry "written" scoreboard, synchronous clear, and a registered write-collision flag.
- Intended as a formal/regression target alongside the existing register-file tests.

Parameters:
- DATA_W, 8, entry width in bits (>=1)
- DEPTH, 4, number of entries (>=2; power of two not required)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- reset  in  1  asynchronous, active-high reset
- clock  in  1  rising-edge clock
- clr  in  1  synchronous clear of all entries and the scoreboard
- wen0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- wen1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- ren0 / ren1  in  1  read enables
- raddr0 / raddr1  in  ADDR_W  read addresses
- rdata0 / rdata1  out  DATA_W  registered read data
- rvalid0 / rvalid1  out  1  registered read-valid strobes
- written  out  DEPTH  bit i = 1 when entry i has been written since last reset/clr
- wcollide  out  1  one-cycle pulse: both ports wrote the same address in the previous cycle
- addr_err  out  1  one-cycle pulse: any enabled access in the previous cycle used an address >= DEPTH

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-operation; any in-flight read is discarded. Reset clears:
  - all entries to 0
  - rdata0/1 = 0, rvalid0/1 = 0
  - written = 0, wcollide = 0, addr_err = 0
- Writes, sampled on the rising clock edge:
  - Port k with wenk=1 and waddrk < DEPTH writes wdatak and sets written[waddrk].
  - Both ports to the same valid address: port 1 data is stored; wcollide = 1 on the next cycle.
  - Both ports to different addresses: both are stored in the same cycle.
- Reads:
  - renk=1 at edge N: rdatak and rvalidk=1 are presented after edge N.
  - renk=0: rvalidk = 0 and rdatak holds its last value.
  - Read-during-write to the same address returns the pre-write (old) value; see Optional Feature.
- Out-of-range addresses (>= DEPTH):
  - Write is dropped; no entry or written bit changes.
  - Read returns rdata = 0 with rvalid = 1.
  - addr_err = 1 on the next cycle.
- clr:
  - At the edge, all entries = 0 and written = 0.
  - Same-cycle writes are discarded; clr has precedence.
  - wcollide and addr_err are still reported for those writes.
  - Same-cycle reads return the pre-clear contents.
- wcollide and addr_err are single-cycle pulses, recomputed every cycle.
- No state machine. Storage is a DEPTH x DATA_W array; the only sequential elements are the array, the read registers and the flag registers.

Optional Feature:
- Macro: REG_FILE_2W2R_BYPASS_EN
- Defined: write-to-read forwarding.
  - A read whose address matches a same-cycle enabled, in-range write returns the new data.
  - If both ports write that address, port 1 data is returned.
  - A read in the same cycle as clr returns 0.
- Undefined:
  - Read-during-write returns the old stored value.
  - A read in the same cycle as clr returns the pre-clear contents.
- Width, latency and flag behaviour are identical in both builds.

Test Plan:
- Reset then read all 4 addresses -> rdata=0x00 with rvalid=1 one cycle after each request; written=4'b0000.
- wen0 addr1=0xA5, then ren0 addr1 and ren1 addr1 -> rdata0=rdata1=0xA5; written=4'b0010.
- wen0 addr2=0x11 and wen1 addr2=0x22 in the same cycle -> entry2=0x22; wcollide=1 for exactly one cycle.
- Entry3=0x33, then wen0 addr3=0x44 with ren1 addr3 in the same cycle:
  - bypass undefined -> rdata1=0x33
  - bypass defined -> rdata1=0x44
  - both builds -> the next read returns 0x44
- DEPTH=3 build: wen0 addr3=0xFF and ren0 addr3 -> no write; rdata0=0; addr_err=1 for one cycle; written unchanged.
- Entries filled, then clr asserted with wen1 addr0=0x77 -> all entries 0, written=0, write discarded. Then assert reset mid-read -> rvalid drops to 0 immediately.

Source files
------------

// File: rtl/reg_file_2w2r_if.sv
// reg_file_2w2r_if -- bus bundle for the two-write / two-read register file.
//
// Groups every non-clock, non-reset signal of reg_file_2w2r.
//   clr                 synchronous clear of all entries and the scoreboard
//   wen0/waddr0/wdata0  write port 0
//   wen1/waddr1/wdata1  write port 1 (wins on a same-address write)
//   ren0/raddr0         read port 0 request
//   ren1/raddr1         read port 1 request
//   rdata0/rdata1       registered read data (1-cycle latency)
//   rvalid0/rvalid1     registered read-valid strobes
//   written             per-entry "written since reset/clr" scoreboard
//   wcollide            pulse: both ports wrote the same valid address last cycle
//   addr_err            pulse: an enabled access used an address >= DEPTH last cycle
//
// Modports: master drives requests (bench / surrounding logic), slave is the
// register file itself.
interface reg_file_2w2r_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
);
    logic              clr;
    logic              wen0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              wen1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              ren0;
    logic [ADDR_W-1:0] raddr0;
    logic              ren1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DEPTH-1:0]  written;
    logic              wcollide;
    logic              addr_err;

    modport master (
        output clr,
        output wen0, waddr0, wdata0,
        output wen1, waddr1, wdata1,
        output ren0, raddr0,
        output ren1, raddr1,
        input  rdata0, rdata1, rvalid0, rvalid1,
        input  written, wcollide, addr_err
    );

    modport slave (
        input  clr,
        input  wen0, waddr0, wdata0,
        input  wen1, waddr1, wdata1,
        input  ren0, raddr0,
        input  ren1, raddr1,
        output rdata0, rdata1, rvalid0, rvalid1,
        output written, wcollide, addr_err
    );
endinterface

// File: rtl/reg_file_2w2r.sv
// reg_file_2w2r -- DEPTH x DATA_W register file, two write ports, two
// synchronous read ports (1-cycle latency), per-entry written scoreboard,
// synchronous clear and registered collision / address-error pulses.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset (clears storage and all outputs)
//   bus    reg_file_2w2r_if.slave -- requests in, read data / flags out
//
// Build option:
//   REG_FILE_2W2R_BYPASS_EN  when defined, a read returns the contents the
//   array will hold after the current edge (same-cycle write data, port 1
//   winning; 0 under clr). When undefined, a read returns the pre-edge
//   contents. Latency, widths and flags are the same in both builds.
module reg_file_2w2r #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input logic                 clock,
    input logic                 reset,
    reg_file_2w2r_if.slave      bus
);

    if (DATA_W < 1 || DEPTH < 2 || (2 ** ADDR_W) < DEPTH) begin : g_param_check
        $error("reg_file_2w2r: illegal DATA_W/DEPTH/ADDR_W combination");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              wcollide_q, wcollide_d;
    logic              addr_err_q, addr_err_d;

    // Address decode is done by matching against every legal entry index, so
    // an address >= DEPTH simply never hits and needs no separate masking.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [DATA_W-1:0] arr [DEPTH],
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) v = arr[i];
        end
        return v;
    endfunction

    // Next array contents: clr beats both writes, port 1 beats port 0.
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.clr) begin
                mem_d[i]     = '0;
                written_d[i] = 1'b0;
            end else if (bus.wen1 && bus.waddr1 == ADDR_W'(i)) begin
                mem_d[i]     = bus.wdata1;
                written_d[i] = 1'b1;
            end else if (bus.wen0 && bus.waddr0 == ADDR_W'(i)) begin
                mem_d[i]     = bus.wdata0;
                written_d[i] = 1'b1;
            end
        end
    end

    // Forwarding falls out of reading the post-edge image (mem_d), which
    // already folds in write priority and clr.
    logic [DATA_W-1:0] rd0, rd1;
    always_comb begin
`ifdef REG_FILE_2W2R_BYPASS_EN
        rd0 = read_mux(mem_d, bus.raddr0);
        rd1 = read_mux(mem_d, bus.raddr1);
`else
        rd0 = read_mux(mem_q, bus.raddr0);
        rd1 = read_mux(mem_q, bus.raddr1);
`endif
    end

    always_comb begin
        rdata0_d  = bus.ren0 ? rd0 : rdata0_q;
        rdata1_d  = bus.ren1 ? rd1 : rdata1_q;
        rvalid0_d = bus.ren0;
        rvalid1_d = bus.ren1;

        // Flags ignore clr: the attempted writes are still reported.
        wcollide_d = bus.wen0 && bus.wen1 && (bus.waddr0 == bus.waddr1)
                     && in_range(bus.waddr0);
        addr_err_d = (bus.wen0 && !in_range(bus.waddr0))
                   || (bus.wen1 && !in_range(bus.waddr1))
                   || (bus.ren0 && !in_range(bus.raddr0))
                   || (bus.ren1 && !in_range(bus.raddr1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            wcollide_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            written_q  <= written_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            wcollide_q <= wcollide_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.written  = written_q;
    assign bus.wcollide = wcollide_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_file_2w2r.sv
module tb_reg_file_2w2r;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 3;   // one spare address bit so addresses 4..7 are out of range

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    reg_file_2w2r_if #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) bus ();

    reg_file_2w2r #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an array of entry values, updated once per edge.
    logic [DW-1:0] m_mem [DP];
    logic [DP-1:0] m_written = '0;
    logic [DW-1:0] e_rdata0 = '0, e_rdata1 = '0;
    logic          e_rvalid0 = 0, e_rvalid1 = 0, e_wcol = 0, e_aerr = 0;

    function automatic logic [DW-1:0] mread(input logic [DW-1:0] arr [DP], input int a);
        return (a < DP) ? arr[a] : '0;
    endfunction

    initial begin
        logic [DW-1:0] pre [DP];
        logic [DW-1:0] post [DP];
        int a0, a1, r0, r1;
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                for (int i = 0; i < DP; i++) m_mem[i] = '0;
                m_written = '0;
                e_rdata0 = '0; e_rdata1 = '0;
                e_rvalid0 = 0; e_rvalid1 = 0; e_wcol = 0; e_aerr = 0;
            end else begin
                a0 = int'(bus.waddr0); a1 = int'(bus.waddr1);
                r0 = int'(bus.raddr0); r1 = int'(bus.raddr1);
                pre = m_mem;
                post = m_mem;
                if (bus.clr) begin
                    for (int i = 0; i < DP; i++) post[i] = '0;
                    m_written = '0;
                end else begin
                    if (bus.wen0 && a0 < DP) begin post[a0] = bus.wdata0; m_written[a0] = 1'b1; end
                    if (bus.wen1 && a1 < DP) begin post[a1] = bus.wdata1; m_written[a1] = 1'b1; end
                end
`ifdef REG_FILE_2W2R_BYPASS_EN
                if (bus.ren0) e_rdata0 = mread(post, r0);
                if (bus.ren1) e_rdata1 = mread(post, r1);
`else
                if (bus.ren0) e_rdata0 = mread(pre, r0);
                if (bus.ren1) e_rdata1 = mread(pre, r1);
`endif
                e_rvalid0 = bus.ren0;
                e_rvalid1 = bus.ren1;
                e_wcol = bus.wen0 && bus.wen1 && a0 == a1 && a0 < DP;
                e_aerr = (bus.wen0 && a0 >= DP) || (bus.wen1 && a1 >= DP)
                      || (bus.ren0 && r0 >= DP) || (bus.ren1 && r1 >= DP);
                m_mem = post;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check("rdata0",   bus.rdata0,   e_rdata0);
            check("rdata1",   bus.rdata1,   e_rdata1);
            check("rvalid0",  bus.rvalid0,  e_rvalid0);
            check("rvalid1",  bus.rvalid1,  e_rvalid1);
            check("written",  bus.written,  m_written);
            check("wcollide", bus.wcollide, e_wcol);
            check("addr_err", bus.addr_err, e_aerr);
        end
    end

    task automatic idle();
        bus.clr = 0;
        bus.wen0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.wen1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.ren0 = 0; bus.raddr0 = '0;
        bus.ren1 = 0; bus.raddr1 = '0;
    endtask

    task automatic wr0(input int a, input int d);
        bus.wen0 = 1; bus.waddr0 = AW'(a); bus.wdata0 = DW'(d);
    endtask

    task automatic wr1(input int a, input int d);
        bus.wen1 = 1; bus.waddr1 = AW'(a); bus.wdata1 = DW'(d);
    endtask

    task automatic cyc();
        @(negedge clock);
        idle();
    endtask

    initial begin
        idle();
        #1 reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        check("reset written", bus.written, 4'b0000);
        check("reset rvalid0", bus.rvalid0, 1'b0);

        // Read every address after reset.
        for (int a = 0; a < DP; a++) begin
            bus.ren0 = 1; bus.raddr0 = AW'(a);
            cyc();
            check("post-reset rdata0", bus.rdata0, 8'h00);
            check("post-reset rvalid0", bus.rvalid0, 1'b1);
        end

        // Single write then dual read.
        wr0(1, 8'hA5); cyc();
        bus.ren0 = 1; bus.raddr0 = 1; bus.ren1 = 1; bus.raddr1 = 1; cyc();
        check("A5 rdata0", bus.rdata0, 8'hA5);
        check("A5 rdata1", bus.rdata1, 8'hA5);
        check("A5 written", bus.written, 4'b0010);

        // Same-address collision: port 1 wins, one-cycle pulse.
        wr0(2, 8'h11); wr1(2, 8'h22); cyc();
        check("collide pulse", bus.wcollide, 1'b1);
        bus.ren0 = 1; bus.raddr0 = 2; cyc();
        check("collide cleared", bus.wcollide, 1'b0);
        check("collide data", bus.rdata0, 8'h22);

        // Read during write.
        wr0(3, 8'h33); cyc();
        wr0(3, 8'h44); bus.ren1 = 1; bus.raddr1 = 3; cyc();
`ifdef REG_FILE_2W2R_BYPASS_EN
        check("rdw rdata1", bus.rdata1, 8'h44);
`else
        check("rdw rdata1", bus.rdata1, 8'h33);
`endif
        bus.ren1 = 1; bus.raddr1 = 3; cyc();
        check("rdw next", bus.rdata1, 8'h44);

        // Out-of-range write and read.
        wr0(4, 8'hFF); bus.ren0 = 1; bus.raddr0 = 4; cyc();
        check("oor rdata0", bus.rdata0, 8'h00);
        check("oor rvalid0", bus.rvalid0, 1'b1);
        check("oor addr_err", bus.addr_err, 1'b1);
        check("oor written", bus.written, 4'b1110);
        cyc();
        check("oor addr_err clr", bus.addr_err, 1'b0);

        // Fill, then clr with a discarded write and an out-of-range write.
        wr0(0, 8'h01); wr1(1, 8'h02); cyc();
        wr0(2, 8'h03); wr1(3, 8'h04); cyc();
        check("fill written", bus.written, 4'b1111);
        bus.clr = 1; wr1(0, 8'h77); wr0(5, 8'h55); cyc();
        check("clr written", bus.written, 4'b0000);
        check("clr addr_err", bus.addr_err, 1'b1);
        bus.ren0 = 1; bus.raddr0 = 0; cyc();
        check("clr entry0", bus.rdata0, 8'h00);

        // Randomized traffic with a bias toward collisions and spare addresses.
        for (int n = 0; n < 3000; n++) begin
            bus.clr    = ($urandom_range(0, 31) == 0);
            bus.wen0   = $urandom_range(0, 1) == 1;
            bus.waddr0 = AW'($urandom_range(0, 5));
            bus.wdata0 = DW'($urandom);
            bus.wen1   = $urandom_range(0, 1) == 1;
            bus.waddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : AW'($urandom_range(0, 5));
            bus.wdata1 = DW'($urandom);
            bus.ren0   = $urandom_range(0, 2) != 0;
            bus.raddr0 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : AW'($urandom_range(0, 5));
            bus.ren1   = $urandom_range(0, 2) != 0;
            bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr1 : AW'($urandom_range(0, 7));
            @(negedge clock);
        end
        idle();

        // Reset asserted while a read result is being presented.
        wr0(1, 8'h5A); cyc();
        bus.ren0 = 1; bus.raddr0 = 1;
        @(posedge clock);
        #2;
        check("pre-reset rvalid0", bus.rvalid0, 1'b1);
        check("pre-reset rdata0", bus.rdata0, 8'h5A);
        reset = 1;
        #1;
        check("async rvalid0", bus.rvalid0, 1'b0);
        check("async rdata0", bus.rdata0, 8'h00);
        check("async written", bus.written, 4'b0000);
        idle();
        @(negedge clock);
        reset = 0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
